// File: rtl/main_control_fsm.sv
// Multicycle main control FSM for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       illegal_q;

    logic is_mem;
    logic is_r;
    logic is_beq;
    logic is_j;
    logic is_imm;
    logic is_legal;

    assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_r     = (opcode == OP_R);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI);
    assign is_legal = is_mem | is_r | is_beq | is_j | is_imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= opcode;
                if (!is_legal)
                    illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                // Unsupported opcodes fall through to FETCH
                unique case (1'b1)
                    is_mem:  state_d = MEMADR;
                    is_r:    state_d = EXEC;
                    is_beq:  state_d = BRANCH;
                    is_j:    state_d = JUMP;
                    is_imm:  state_d = IMMEX;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
                state_d   = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;

endmodule
